// File: rtl/mlab_stream_fifo_if.sv
// rtl/mlab_stream_fifo_if.sv - producer/consumer stream bundle for mlab_stream_fifo
interface mlab_stream_fifo_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [WIDTH-1:0]    din;
    logic                din_valid;
    logic                din_ready;
    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic                dout_ready;
    logic [ADDR_WIDTH:0] used;

    // FIFO side
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, used
    );

    // Producer/consumer side
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, used
    );
endinterface

// File: rtl/mlab_stream_fifo.sv
// rtl/mlab_stream_fifo.sv - show-ahead valid/ready FIFO on an MLAB with registered output
module mlab_stream_fifo #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int TARGET_CHIP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mlab_stream_fifo_if.slave     fifo_if
);
    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    // Write pipeline: accepted word waits one cycle before its MLAB write edge
    logic                  wpend_q,  wpend_d;
    logic [WIDTH-1:0]      wdata_q,  wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q,  waddr_d;
    // Read side
    logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
    logic [ADDR_WIDTH:0]   commit_q, commit_d;
    logic [WIDTH-1:0]      dout_q,   dout_d;
    logic                  dvalid_q, dvalid_d;
    // Occupancy across RAM, write pipeline and output register
    logic [ADDR_WIDTH:0]   used_q,   used_d;

    logic                  din_ready;
    logic                  accept;
    logic                  pop;
    logic                  load;
    logic [WIDTH-1:0]      rd_data;

    // Ready comes only from registered occupancy; held low while reset is asserted
    assign din_ready = rst_n && (used_q < FULL_COUNT);
    assign accept    = fifo_if.din_valid && din_ready;
    assign pop       = dvalid_q && fifo_if.dout_ready;
    // Only committed entries are read, so raddr never hits an address with a write in flight
    assign load      = (commit_q != '0) && (!dvalid_q || pop);

    assign fifo_if.din_ready  = din_ready;
    assign fifo_if.dout       = dout_q;
    assign fifo_if.dout_valid = dvalid_q;
    assign fifo_if.used       = used_q;

    // MLAB storage: registered write, unregistered read address; contents are never reset
    generate
        if (TARGET_CHIP == 2) begin : g_s5mlab
            logic [WIDTH-1:0] mem [DEPTH];
            // Stratix V MLAB write port
            always_ff @(posedge clk) begin
                if (wpend_q) begin
                    mem[waddr_q] <= wdata_q;
                end
            end
            assign rd_data = mem[raddr_q];
        end else begin : g_s4mlab
            logic [WIDTH-1:0] mem [DEPTH];
            // Stratix IV MLAB write port
            always_ff @(posedge clk) begin
                if (wpend_q) begin
                    mem[waddr_q] <= wdata_q;
                end
            end
            assign rd_data = mem[raddr_q];
        end
    endgenerate

    // Next-state for pointers, commit count, output register and occupancy
    always_comb begin
        wpend_d  = accept;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        commit_d = commit_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        used_d   = used_q;

        if (accept) begin
            wdata_d = fifo_if.din;
        end

        if (wpend_q) begin
            waddr_d = waddr_q + PTR_ONE;
        end

        // Entry becomes readable the cycle after its write edge
        if (wpend_q && !load) begin
            commit_d = commit_q + CNT_ONE;
        end else if (!wpend_q && load) begin
            commit_d = commit_q - CNT_ONE;
        end

        if (load) begin
            dout_d   = rd_data;
            dvalid_d = 1'b1;
            raddr_d  = raddr_q + PTR_ONE;
        end else if (pop) begin
            dvalid_d = 1'b0;
        end

        if (accept && !pop) begin
            used_d = used_q + CNT_ONE;
        end else if (!accept && pop) begin
            used_d = used_q - CNT_ONE;
        end
    end

    // State registers; reset discards everything including a word in the write pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wpend_q  <= 1'b0;
            wdata_q  <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            commit_q <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            used_q   <= '0;
        end else begin
            wpend_q  <= wpend_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            commit_q <= commit_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            used_q   <= used_d;
        end
    end
endmodule

// File: tb/tb_mlab_stream_fifo.sv
// tb/tb_mlab_stream_fifo.sv - directed self-checking bench for mlab_stream_fifo
module tb_mlab_stream_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    mlab_stream_fifo_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

    mlab_stream_fifo #(.WIDTH(32), .ADDR_WIDTH(5), .TARGET_CHIP(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int acc_cnt, last_acc, errs, cyc, next_in, exp_out, model_used, max_used, outs;
        logic acc, pp;

        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        check("rst_din_ready", 64'(bus.din_ready), 64'd0);
        check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_dout", 64'(bus.dout), 64'd0);
        check("rst_used", 64'(bus.used), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_din_ready", 64'(bus.din_ready), 64'd1);

        // Single word latency
        bus.din = 32'hA5A5A5A5; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        check("single_used_n", 64'(bus.used), 64'd1);
        check("single_valid_n", 64'(bus.dout_valid), 64'd0);
        tick();
        check("single_valid_n1", 64'(bus.dout_valid), 64'd0);
        tick();
        check("single_valid_n2", 64'(bus.dout_valid), 64'd1);
        check("single_dout_n2", 64'(bus.dout), 64'hA5A5A5A5);
        check("single_used_n2", 64'(bus.used), 64'd1);
        tick();
        check("single_used_pop", 64'(bus.used), 64'd0);
        check("single_valid_pop", 64'(bus.dout_valid), 64'd0);

        // Fill with consumer stalled
        bus.dout_ready = 1'b0;
        acc_cnt = 0; last_acc = -1; errs = 0;
        for (int i = 0; i <= 40; i++) begin
            bus.din = 32'(i); bus.din_valid = 1'b1;
            if (bus.din_ready) begin acc_cnt++; last_acc = i; end
            if (bus.dout_valid && bus.dout !== 32'd0) errs++;
            tick();
        end
        bus.din_valid = 1'b0;
        check("fill_accepted", 64'(acc_cnt), 64'd32);
        check("fill_last", 64'(last_acc), 64'd31);
        check("fill_head_stable", 64'(errs), 64'd0);
        check("fill_used", 64'(bus.used), 64'd32);
        check("fill_din_ready", 64'(bus.din_ready), 64'd0);
        check("fill_dout", 64'(bus.dout), 64'd0);
        check("fill_dout_valid", 64'(bus.dout_valid), 64'd1);

        // Full with simultaneous pop: push rejected
        bus.din = 32'd99; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
        tick();
        bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
        check("fullpop_used", 64'(bus.used), 64'd31);
        check("fullpop_dout", 64'(bus.dout), 64'd1);
        check("fullpop_din_ready", 64'(bus.din_ready), 64'd1);

        // Drain 1..31; the rejected 99 must never appear
        bus.dout_ready = 1'b1;
        exp_out = 1; errs = 0; cyc = 0;
        while (bus.used != 0 && cyc < 100) begin
            if (bus.dout_valid) begin
                if (bus.dout !== 32'(exp_out)) errs++;
                exp_out++;
            end
            tick();
            cyc++;
        end
        check("drain_order", 64'(errs), 64'd0);
        check("drain_last", 64'(exp_out), 64'd32);

        // Streaming 0..199 with random consumer stalls
        next_in = 0; exp_out = 0; model_used = 0; max_used = 0; errs = 0; cyc = 0;
        while (exp_out < 200 && cyc < 3000) begin
            bus.din_valid  = (next_in < 200);
            bus.din        = 32'(next_in);
            bus.dout_ready = ($urandom_range(0, 3) != 0) ? ~bus.dout_ready : bus.dout_ready;
            acc = bus.din_valid && bus.din_ready;
            pp  = bus.dout_valid && bus.dout_ready;
            if (pp) begin
                if (bus.dout !== 32'(exp_out)) errs++;
                exp_out++;
            end
            tick();
            if (acc) next_in++;
            model_used = model_used + int'(acc) - int'(pp);
            if (bus.used !== 6'(model_used)) errs++;
            if (int'(bus.used) > max_used) max_used = int'(bus.used);
            cyc++;
        end
        bus.din_valid = 1'b0;
        check("stream_count", 64'(exp_out), 64'd200);
        check("stream_in_count", 64'(next_in), 64'd200);
        check("stream_errors", 64'(errs), 64'd0);
        check("stream_max_used", 64'(max_used <= 32), 64'd1);
        check("stream_used_end", 64'(bus.used), 64'd0);

        // Back-pressure hold on word 7
        bus.dout_ready = 1'b0;
        next_in = 7;
        for (int k = 0; k < 3; k++) begin
            bus.din = 32'(next_in); bus.din_valid = 1'b1;
            tick();
            next_in++;
        end
        check("hold_first_valid", 64'(bus.dout_valid), 64'd1);
        check("hold_first_dout", 64'(bus.dout), 64'd7);
        for (int k = 0; k < 5; k++) begin
            bus.din = 32'(next_in);
            tick();
            next_in++;
            check("hold_dout", 64'(bus.dout), 64'd7);
            check("hold_valid", 64'(bus.dout_valid), 64'd1);
        end
        check("hold_used", 64'(bus.used), 64'd8);

        // Bring used to 10 with the last word still in the write pipeline
        cyc = 0;
        while (bus.used < 10 && cyc < 20) begin
            bus.din = 32'(next_in);
            tick();
            next_in++;
            cyc++;
        end
        check("pre_rst_used", 64'(bus.used), 64'd10);
        bus.din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("midrst_dout", 64'(bus.dout), 64'd0);
        check("midrst_used", 64'(bus.used), 64'd0);
        check("midrst_din_ready", 64'(bus.din_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 64'(bus.din_ready), 64'd1);

        // Single post-reset word is the only output
        bus.din = 32'h55; bus.din_valid = 1'b1; bus.dout_ready = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        check("post_rst_valid_n", 64'(bus.dout_valid), 64'd0);
        tick();
        check("post_rst_valid_n1", 64'(bus.dout_valid), 64'd0);
        tick();
        check("post_rst_valid_n2", 64'(bus.dout_valid), 64'd1);
        check("post_rst_dout", 64'(bus.dout), 64'h55);
        outs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.dout_valid) outs++;
        end
        check("post_rst_extra_outputs", 64'(outs), 64'd0);
        check("post_rst_used_end", 64'(bus.used), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
